// File: rtl/ysyx_220053_div_unit_pkg.sv
// ysyx_220053_div_unit_pkg: shared width, FSM states, latched op flags and W-form sign-extension helper.
package ysyx_220053_div_unit_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  typedef struct packed {
    logic word;
    logic rem;
  } op_t;
  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction
endpackage

// File: rtl/ysyx_220053_div_unit_if.sv
// ysyx_220053_div_unit_if: EXU<->divider bus; master drives request/flush/out_ready, slave returns in_ready/out_valid/out_result.
interface ysyx_220053_div_unit_if;
  logic in_valid;
  logic in_ready;
  logic [ysyx_220053_div_unit_pkg::XLEN-1:0] in_a;
  logic [ysyx_220053_div_unit_pkg::XLEN-1:0] in_b;
  logic in_signed;
  logic in_word;
  logic in_rem;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [ysyx_220053_div_unit_pkg::XLEN-1:0] out_result;
  modport master(output in_valid, in_a, in_b, in_signed, in_word, in_rem, flush, out_ready,
                 input in_ready, out_valid, out_result);
  modport slave(input in_valid, in_a, in_b, in_signed, in_word, in_rem, flush, out_ready,
                output in_ready, out_valid, out_result);
endinterface

// File: rtl/ysyx_220053_div_unit_iter.sv
// ysyx_220053_div_unit_iter: one combinational restoring step (rem_in, quo_in, divisor -> rem_out, quo_out).
module ysyx_220053_div_unit_iter
  import ysyx_220053_div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] diff;
  logic borrow;
  assign diff = {rem_in, quo_in[XLEN-1]} - {1'b0, divisor};
  assign borrow = diff[XLEN];
  assign rem_out = borrow ? {rem_in[XLEN-2:0], quo_in[XLEN-1]} : diff[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], ~borrow};
endmodule

// File: rtl/ysyx_220053_div_unit.sv
// ysyx_220053_div_unit: multi-cycle RV64M DIV/REM unit; clk, async rst_n, bus (slave) carries request, flush and result handshakes.
module ysyx_220053_div_unit
  import ysyx_220053_div_unit_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ysyx_220053_div_unit_if.slave bus
);
  state_t state, nxt;
  op_t op;
  logic [5:0] cnt;
  logic neg_q, neg_r, acc, sgn_a, sgn_b, zero_b, ovf;
  logic [XLEN-1:0] a_v, b_v, a_abs, b_abs, min_v, dvs, rem_q, quo_q, rem_n, quo_n, res;
  assign a_v = bus.in_word ? {{(XLEN-32){bus.in_signed & bus.in_a[31]}}, bus.in_a[31:0]} : bus.in_a;
  assign b_v = bus.in_word ? {{(XLEN-32){bus.in_signed & bus.in_b[31]}}, bus.in_b[31:0]} : bus.in_b;
  assign min_v = bus.in_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign sgn_a = bus.in_signed & a_v[XLEN-1];
  assign sgn_b = bus.in_signed & b_v[XLEN-1];
  assign a_abs = sgn_a ? -a_v : a_v;
  assign b_abs = sgn_b ? -b_v : b_v;
  assign zero_b = b_v == '0;
  assign ovf = bus.in_signed & (a_v == min_v) & (&b_v);
  assign acc = bus.in_valid & (state == S_IDLE) & ~bus.flush;
  assign bus.in_ready = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.out_result = res;
  ysyx_220053_div_unit_iter u_iter (
    .rem_in(rem_q), .quo_in(quo_q), .divisor(dvs), .rem_out(rem_n), .quo_out(quo_n)
  );
  always_comb begin
    nxt = bus.flush ? S_IDLE :
          state == S_IDLE ? (acc ? ((zero_b | ovf) ? S_DONE : S_CALC) : S_IDLE) :
          state == S_CALC ? (cnt == 6'd0 ? S_FIX : S_CALC) :
          state == S_FIX  ? S_DONE :
          bus.out_ready   ? S_IDLE : S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvs <= '0;
      rem_q <= '0;
      quo_q <= '0;
      res <= '0;
    end else if (acc) begin
      op <= '{word: bus.in_word, rem: bus.in_rem};
      cnt <= bus.in_word ? 6'd31 : 6'd63;
      neg_q <= sgn_a ^ sgn_b;
      neg_r <= sgn_a;
      dvs <= b_abs;
      rem_q <= '0;
      // W forms park the 32-bit dividend in the top half so the step always shifts out bit XLEN-1
      quo_q <= bus.in_word ? a_abs << 32 : a_abs;
      if (zero_b | ovf)
        res <= sext_w(bus.in_word, bus.in_rem ? (zero_b ? a_v : '0) : (zero_b ? '1 : a_v));
    end else if (state == S_CALC) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt <= cnt - 6'd1;
    end else if (state == S_FIX) begin
      res <= sext_w(op.word, op.rem ? (neg_r ? -rem_q : rem_q) : (neg_q ? -quo_q : quo_q));
    end
  end
endmodule
